// File: rtl/rgb_row_assembler_pkg.sv
// Shared sizing and FSM state type for the RGB row assembler.
package rgb_row_assembler_pkg;
    localparam int COLS  = 256;
    localparam int ROWS  = 256;
    localparam int PIX_W = 24;
    localparam int CH_W  = 8;

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
endpackage

// File: rtl/rgb_row_buffer.sv
// Row assembly shift register: pixels enter at the LSB end, so pixel 0 ends up at the MSB end.
module rgb_row_buffer #(
    parameter int COLS  = rgb_row_assembler_pkg::COLS,
    parameter int PIX_W = rgb_row_assembler_pkg::PIX_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clr,
    input  logic                    shift,
    input  logic [PIX_W-1:0]        din,
    output logic [COLS*PIX_W-1:0]   data
);
    localparam int W = COLS * PIX_W;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data <= '0;
        end else if (clr) begin
            // clear with shift restarts the row with din as its first pixel
            data <= shift ? {{(W-PIX_W){1'b0}}, din} : '0;
        end else if (shift) begin
            data <= {data[W-PIX_W-1:0], din};
        end
    end
endmodule

// File: rtl/rgb_row_assembler.sv
// Assembles a raster RGB pixel stream into double-buffered packed rows with row index and frame tracking.
//   state | meaning
//   IDLE  | waiting for pix_sof, other pixels dropped
//   FILL  | shifting pixels of the current row into the buffer
//   FULL  | row complete in buffer, waiting for the output slot
module rgb_row_assembler #(
    parameter int COLS  = rgb_row_assembler_pkg::COLS,
    parameter int ROWS  = rgb_row_assembler_pkg::ROWS,
    parameter int PIX_W = rgb_row_assembler_pkg::PIX_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [PIX_W-1:0]          pix_in,
    input  logic                      pix_valid,
    input  logic                      pix_sof,
    output logic                      pix_ready,
    output logic [COLS*PIX_W-1:0]     row_out,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [$clog2(ROWS)-1:0]   row_idx,
    output logic                      frame_done,
    output logic                      sof_err
);
    import rgb_row_assembler_pkg::*;

    localparam int W  = COLS * PIX_W;
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    state_t         state, state_d;
    logic [CW-1:0]  col, col_d;
    logic [RW-1:0]  row, row_d;
    logic           shift, clr, load, load_from_buf, sof_err_d;
    logic           pix_acc, slot_free;
    logic [W-1:0]   buf_data;
    logic [W-1:0]   load_data;

    assign pix_ready = !RST && (state != FULL);
    assign pix_acc   = pix_valid && pix_ready;
    assign slot_free = !row_valid || row_ready;
    assign load_data = load_from_buf ? buf_data : {buf_data[W-PIX_W-1:0], pix_in};

    rgb_row_buffer #(.COLS(COLS), .PIX_W(PIX_W)) u_buf (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (clr),
        .shift (shift),
        .din   (pix_in),
        .data  (buf_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_d;
            col   <= col_d;
            row   <= row_d;
        end
    end

    always_comb begin
        state_d       = state;
        col_d         = col;
        row_d         = row;
        shift         = 1'b0;
        clr           = 1'b0;
        load          = 1'b0;
        load_from_buf = 1'b0;
        sof_err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (pix_acc && pix_sof) begin
                    clr     = 1'b1;
                    shift   = 1'b1;
                    col_d   = CW'(1);
                    row_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (pix_acc) begin
                    shift = 1'b1;
                    if (pix_sof && (col != '0 || row != '0)) begin
                        clr       = 1'b1;
                        col_d     = CW'(1);
                        row_d     = '0;
                        sof_err_d = 1'b1;
                    end else if (col == COL_LAST) begin
                        if (slot_free) begin
                            load = 1'b1;
                        end else begin
                            state_d = FULL;
                        end
                    end else begin
                        col_d = col + CW'(1);
                    end
                end
            end
            FULL: begin
                if (slot_free) begin
                    load          = 1'b1;
                    load_from_buf = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // a loaded row advances to the next row or ends the frame
        if (load) begin
            col_d = '0;
            if (row == ROW_LAST) begin
                row_d   = '0;
                state_d = IDLE;
            end else begin
                row_d   = row + RW'(1);
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_out    <= '0;
            row_valid  <= 1'b0;
            row_idx    <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            frame_done <= row_valid && row_ready && (row_idx == ROW_LAST);
            sof_err    <= sof_err_d;
            if (load) begin
                row_out   <= load_data;
                row_idx   <= row;
                row_valid <= 1'b1;
            end else if (row_ready) begin
                row_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rgb_row_assembler.sv
// Randomized bench for rgb_row_assembler (COLS=4, ROWS=2) against a queue-based row model.
module tb_rgb_row_assembler;
    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int PIX_W = 24;
    localparam int W     = COLS * PIX_W;
    localparam int RW    = $clog2(ROWS);

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [PIX_W-1:0]     pix_in = '0;
    logic                 pix_valid = 1'b0;
    logic                 pix_sof = 1'b0;
    logic                 pix_ready;
    logic [W-1:0]         row_out;
    logic                 row_valid;
    logic                 row_ready = 1'b1;
    logic [RW-1:0]        row_idx;
    logic                 frame_done;
    logic                 sof_err;

    rgb_row_assembler #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .row_out    (row_out),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_idx    (row_idx),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_count = 0;
    int se_count = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // reference model: rows completed by the input but not yet taken downstream
    typedef struct {
        logic [W-1:0]  data;
        logic [RW-1:0] idx;
    } row_t;

    row_t             exp_q[$];
    logic [PIX_W-1:0] cur[$];
    bit               in_frame = 0;
    int               mrow = 0;
    bit               exp_fd = 0;
    bit               exp_se = 0;

    function automatic logic [W-1:0] pack_row(input logic [PIX_W-1:0] q[$]);
        logic [W-1:0] v = '0;
        for (int k = 0; k < COLS; k++) v[W-1-PIX_W*k -: PIX_W] = q[k];
        return v;
    endfunction

    task automatic model_pixel(input logic [PIX_W-1:0] p, input logic sof);
        row_t r;
        if (!in_frame) begin
            if (sof) begin
                in_frame = 1;
                mrow = 0;
                cur = {p};
            end
        end else if (sof && (cur.size() != 0 || mrow != 0)) begin
            exp_se = 1;
            mrow = 0;
            cur = {p};
        end else begin
            cur.push_back(p);
        end
        if (cur.size() == COLS) begin
            r.data = pack_row(cur);
            r.idx  = RW'(mrow);
            exp_q.push_back(r);
            cur.delete();
            mrow++;
            if (mrow == ROWS) begin
                in_frame = 0;
                mrow = 0;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            check("rst_row_out", row_out, '0);
            check("rst_row_valid", W'(row_valid), '0);
            check("rst_row_idx", W'(row_idx), '0);
            check("rst_frame_done", W'(frame_done), '0);
            check("rst_sof_err", W'(sof_err), '0);
            check("rst_pix_ready", W'(pix_ready), '0);
            exp_q.delete();
            cur.delete();
            in_frame = 0;
            mrow = 0;
            exp_fd = 0;
            exp_se = 0;
        end else begin
            check("frame_done", W'(frame_done), W'(exp_fd));
            check("sof_err", W'(sof_err), W'(exp_se));
            if (frame_done) fd_count++;
            if (sof_err) se_count++;
            check("pix_ready", W'(pix_ready), W'(exp_q.size() < 2));
            check("row_valid", W'(row_valid), W'(exp_q.size() > 0));
            if (row_valid && exp_q.size() > 0) begin
                check("row_out", row_out, exp_q[0].data);
                check("row_idx", W'(row_idx), W'(exp_q[0].idx));
            end
            exp_fd = 0;
            exp_se = 0;
            if (row_valid && row_ready && exp_q.size() > 0) begin
                if (exp_q[0].idx == RW'(ROWS - 1)) exp_fd = 1;
                void'(exp_q.pop_front());
            end
            if (pix_valid && pix_ready) model_pixel(pix_in, pix_sof);
        end
    end

    task automatic send_pix(input logic [PIX_W-1:0] p, input logic sof);
        int  n = 0;
        bit  acc = 0;
        pix_in = p;
        pix_sof = sof;
        pix_valid = 1'b1;
        do begin
            @(negedge CLK);
            acc = pix_ready;
            @(posedge CLK);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", W'(acc), W'(1));
        pix_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        pix_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            pix_in = PIX_W'($urandom);
            pix_sof = 1'($urandom);
            @(posedge CLK);
            #1;
        end
        pix_sof = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        row_ready = 1'b1;
        while (row_valid && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("drain", W'(row_valid), '0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // mode 0: {row,col,5A} pattern; mode 1: random pixels, bubbles and row_ready
    task automatic send_frame(input int mode, input int bubbles);
        logic [PIX_W-1:0] p;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (mode == 0) p = {8'(r), 8'(c), 8'h5A};
                else begin
                    p = PIX_W'($urandom);
                    row_ready = 1'($urandom);
                end
                if (bubbles > 0) idle_cycles(mode == 0 ? bubbles : $urandom_range(bubbles, 0));
                send_pix(p, (r == 0 && c == 0));
            end
        end
    endtask

    int fd0, se0;
    logic [PIX_W-1:0] rp;

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        idle_cycles(2);

        // continuous frame, downstream always ready
        fd0 = fd_count;
        send_frame(0, 0);
        drain();
        check("t1_frame_done_count", W'(fd_count - fd0), W'(1));

        // backpressure: downstream stalls across row 1
        row_ready = 1'b0;
        for (int i = 0; i < COLS * ROWS; i++)
            send_pix({8'(i / COLS), 8'(i % COLS), 8'h5A}, i == 0);
        repeat (2) @(posedge CLK);
        #1;
        check("bp_full_ready", W'(pix_ready), '0);
        check("bp_full_valid", W'(row_valid), W'(1));
        repeat (8) @(posedge CLK);
        #1;
        row_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_load_valid", W'(row_valid), W'(1));
        check("bp_load_idx", W'(row_idx), W'(1));
        check("bp_load_ready", W'(pix_ready), W'(1));
        drain();

        // junk before sof, then a frame
        for (int i = 0; i < 3; i++) send_pix(PIX_W'($urandom), 1'b0);
        send_frame(0, 0);
        drain();

        // resync at row 0, col 2
        se0 = se_count;
        fd0 = fd_count;
        row_ready = 1'b0;
        send_pix(PIX_W'($urandom), 1'b1);
        send_pix(PIX_W'($urandom), 1'b0);
        rp = PIX_W'($urandom);
        send_pix(rp, 1'b1);
        for (int i = 0; i < COLS - 1; i++) send_pix(PIX_W'($urandom), 1'b0);
        @(negedge CLK);
        check("resync_pix0", W'(row_out[W-1 -: PIX_W]), W'(rp));
        check("resync_idx", W'(row_idx), '0);
        @(posedge CLK);
        #1;
        row_ready = 1'b1;
        for (int i = 0; i < COLS; i++) send_pix(PIX_W'($urandom), 1'b0);
        drain();
        check("resync_sof_err_count", W'(se_count - se0), W'(1));
        check("resync_frame_done_count", W'(fd_count - fd0), W'(1));

        // async reset while FULL with a row held
        row_ready = 1'b0;
        for (int i = 0; i < COLS * ROWS; i++) send_pix(PIX_W'($urandom), i == 0);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("async_row_out", row_out, '0);
        check("async_row_valid", W'(row_valid), '0);
        check("async_row_idx", W'(row_idx), '0);
        check("async_pix_ready", W'(pix_ready), '0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        row_ready = 1'b1;
        send_frame(0, 0);
        drain();

        // bubbles every other cycle, same pattern as the continuous frame
        send_frame(0, 1);
        drain();

        // random frames, back to back
        for (int f = 0; f < 4; f++) send_frame(1, 2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
